// File: rtl/daq_pkg.sv
// Shared definitions for the paged DAQ event buffer: page-size encodings,
// pointer width, default busy thresholds and the page-count mask helper.
package daq_pkg;

    localparam int unsigned LOG2_BUFCOUNT = 6;

    localparam logic [1:0] PS_512  = 2'd0;
    localparam logic [1:0] PS_1024 = 2'd1;
    localparam logic [1:0] PS_2048 = 2'd2;

    localparam logic [LOG2_BUFCOUNT-1:0] BUSY_ON_DEF  = 6'd50;
    localparam logic [LOG2_BUFCOUNT-1:0] BUSY_OFF_DEF = 6'd20;

    // Mask equals npages-1; encodings 2 and 3 both select 2048-word pages.
    function automatic logic [LOG2_BUFCOUNT-1:0] npages_mask(input logic [1:0] page_size);
        logic [LOG2_BUFCOUNT-1:0] mask;
        mask = 6'h0F;
        case (page_size)
            PS_512:  mask = 6'h3F;
            PS_1024: mask = 6'h1F;
            default: mask = 6'h0F;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/daq_page_ptr.sv
// Masked modulo page pointer: advances on request unless blocked, and reports
// both its next value and whether the request was refused.
module daq_page_ptr #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] mask,
    input  logic         advance,
    input  logic         blocked,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_next,
    output logic         refused
);

    logic [W-1:0] ptr_q;

    always_comb begin
        ptr_next = ptr_q;
        refused  = 1'b0;
        if (advance) begin
            if (blocked) begin
                refused = 1'b1;
            end else begin
                // Upper bits beyond the page count are forced to zero by the mask.
                ptr_next = (ptr_q + W'(1)) & mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_next;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/daq_page_scheduler.sv
// Page scheduler for the paged DAQ event buffer: write/read page pointers,
// occupancy, full/empty, busy hysteresis, drop counting and underflow flag.
module daq_page_scheduler
    import daq_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               page_size,
    input  logic                     commit,
    input  logic                     page_release,
    input  logic [LOG2_BUFCOUNT-1:0] busy_on,
    input  logic [LOG2_BUFCOUNT-1:0] busy_off,
    output logic [LOG2_BUFCOUNT-1:0] w_buf_id,
    output logic [LOG2_BUFCOUNT-1:0] r_buf_id,
    output logic [LOG2_BUFCOUNT-1:0] nevents,
    output logic                     empty,
    output logic                     full,
    output logic                     busy,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic                     underflow
);

    logic [1:0]               page_size_r;
    logic [LOG2_BUFCOUNT-1:0] mask;
    logic [LOG2_BUFCOUNT-1:0] w_next;
    logic [LOG2_BUFCOUNT-1:0] r_next;
    logic [LOG2_BUFCOUNT-1:0] nevents_d;
    logic                     commit_refused;
    logic                     release_refused;
    logic                     busy_d;

    assign mask = npages_mask(page_size_r);

    daq_page_ptr #(
        .W (LOG2_BUFCOUNT)
    ) u_wr_ptr (
        .clk      (clk),
        .reset    (reset),
        .mask     (mask),
        .advance  (commit),
        .blocked  (full),
        .ptr      (w_buf_id),
        .ptr_next (w_next),
        .refused  (commit_refused)
    );

    daq_page_ptr #(
        .W (LOG2_BUFCOUNT)
    ) u_rd_ptr (
        .clk      (clk),
        .reset    (reset),
        .mask     (mask),
        .advance  (page_release),
        .blocked  (empty),
        .ptr      (r_buf_id),
        .ptr_next (r_next),
        .refused  (release_refused)
    );

    // Status tracks the next-state pointers so it lines up with the new ids.
    assign nevents_d = (w_next - r_next) & mask;

    // Clear rule first so overlapping thresholds resolve to not-busy.
    always_comb begin
        busy_d = busy;
        if (empty || (nevents <= busy_off)) begin
            busy_d = 1'b0;
        end else if (full || (nevents >= busy_on)) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            page_size_r <= page_size;
            nevents     <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            busy        <= 1'b0;
            drop_count  <= '0;
            underflow   <= 1'b0;
        end else begin
            nevents <= nevents_d;
            empty   <= (nevents_d == '0);
            full    <= (nevents_d == mask);
            busy    <= busy_d;
            if (commit_refused && (drop_count != {DROP_CNT_W{1'b1}})) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
            if (release_refused) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/daq_page_scheduler.md
Name: daq_page_scheduler

Overview:
- Single-clock controller for the paged DAQ event buffer: owns the write-page and read-page pointers, occupancy, and full/empty, busy-hysteresis and drop accounting.
- Sits between the link-side write manager, which commits a page at end-of-event, and the DMA/AXI reader, which releases a page when done.
- Handles the page-size-dependent pointer wrap in one place, so write and read sides cannot disagree.
- CDC of commit/release pulses is done by the instantiating level with SinglePulseDualClock; this block sees single-cycle pulses on clk.

Parameters:
- LOG2_BUFCOUNT, 6, width of page-id pointers; maximum 64 pages.
- DROP_CNT_W, 16, width of the saturating dropped-event counter.

Ports:
- clk  in  1  block clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- page_size  in  2  0=512-word pages/64 pages, 1=1024/32, 2 or 3=2048/16; sampled only during reset.
- commit  in  1  one-cycle pulse: write side finished the current page (end of event).
- release  in  1  one-cycle pulse: reader finished the oldest page.
- busy_on  in  6  occupancy at or above which busy asserts.
- busy_off  in  6  occupancy at or below which busy deasserts.
- w_buf_id  out  6  page currently being written.
- r_buf_id  out  6  oldest unread page.
- nevents  out  6  committed, unreleased pages.
- empty  out  1  nevents==0.
- full  out  1  nevents==npages-1.
- busy  out  1  throttle to trigger logic.
- drop_count  out  DROP_CNT_W  commits rejected because full; saturating.
- underflow  out  1  sticky: release seen while empty.

Behaviour:
- Reset, while reset=1:
  - page_size_r<=page_size; w_buf_id=r_buf_id=0; nevents=0; empty=1; full=0; busy=0; drop_count=0; underflow=0.
  - commit and release are ignored.
- Page geometry:
  - npages = 64, 32 or 16 for page_size_r = 0, 1, or 2/3.
  - Pointer increment is modulo npages. Only the low 6/5/4 bits count; the upper bits are held at 0.
  - page_size changes outside reset have no effect until the next reset.
- Pointer updates, one cycle after the pulse edge:
  - commit && !full: w_buf_id <= w_buf_id+1 (mod npages).
  - commit && full: w_buf_id holds; drop_count increments, saturating at all-ones.
  - release && !empty: r_buf_id <= r_buf_id+1 (mod npages).
  - release && empty: r_buf_id holds; underflow <= 1, cleared only by reset.
- Simultaneous commit and release in the same cycle:
  - Evaluate against the pre-cycle full/empty.
  - If neither is blocked, both pointers advance and nevents is unchanged.
  - If full: the release advances r, the commit is dropped and counted.
  - If empty: the commit advances w, the release flags underflow.
- Status outputs:
  - nevents, empty and full are registered and computed from next-state pointers, so they are valid in the same cycle as the updated pointers.
  - nevents = (w-r) mod npages.
- Busy (registered, one cycle after the nevents change), priority order:
  1. If empty or nevents<=busy_off, busy<=0.
  2. Else if full or nevents>=busy_on, busy<=1.
  3. Else busy holds.
- Overlapping thresholds: if busy_off>=busy_on, the clear rule wins.
- Reset mid-operation discards all pages instantly. Readers must treat r_buf_id=0 after reset as fresh.

Decomposition:
- Shared package daq_pkg holds:
  - page-size encodings PS_512, PS_1024, PS_2048;
  - LOG2_BUFCOUNT;
  - a function npages_mask(page_size) returning 6'h3F/6'h1F/6'h0F;
  - default thresholds BUSY_ON_DEF=50, BUSY_OFF_DEF=20.
- One natural sub-module: daq_page_ptr, a masked modulo incrementer with an advance-enable and blocked flag, instantiated twice (write and read).

Test Plan:
- page_size=0, 63 commits, no release -> full=1 at nevents=63, w_buf_id=63. 64th commit -> w_buf_id stays 63, drop_count=1.
- page_size=2, 20 commits, 5 releases -> w_buf_id=15 and drop_count=5 after the 16th commit (full at 15); r_buf_id=5, nevents=10.
- page_size=1, pointers at w=31, r=30; commit+release in the same cycle -> w=0, r=31, nevents=1, upper bit of both stays 0.
- busy_on=50, busy_off=20, page_size=0:
  - ramp 0 to 50 commits -> busy=1 one cycle after nevents=50;
  - release to 21 -> busy stays 1;
  - release to 20 -> busy=0.
- Release pulse with empty=1 -> r_buf_id stays 0, underflow=1. Then reset -> underflow=0, page_size re-sampled.
- Reset asserted with nevents=12, busy=1 -> next cycle all pointers 0, nevents=0, empty=1, busy=0, drop_count=0.
